// File: rtl/dlatch_write_sequencer.sv
// Drives D/C of a level-sensitive DLatch bank from a valid/ready write stream,
// spacing setup, gate pulse and hold in clock cycles. Optional readback check: DLATCH_SEQ_READBACK_CHECK_EN.
module dlatch_write_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 3,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             follow,
  output logic [WIDTH-1:0] latch_d,
  output logic             latch_c,
  input  logic [WIDTH-1:0] latch_q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, FOLLOW} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            cnt_zero;

  assign cnt_zero = (cnt_reg == '0);
  assign in_ready = (state_reg == IDLE) && !rst;
  assign busy     = (state_reg != IDLE);

`ifdef DLATCH_SEQ_READBACK_CHECK_EN
  logic             sess_follow_reg;
  logic [WIDTH-1:0] diff;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
    assign diff[gi] = latch_q[gi] ^ latch_d[gi];
  end

  // Only normal writes are verified; a follow session ends on whatever D tracked last.
  always_ff @(posedge clk) begin
    if (rst) begin
      err             <= 1'b0;
      sess_follow_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE)
        sess_follow_reg <= follow;
      if (state_reg == HOLD && cnt_zero && !sess_follow_reg && (|diff))
        err <= 1'b1;
    end
  end
`else
  logic unused_q;
  assign unused_q = ^latch_q;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      latch_d   <= '0;
      latch_c   <= 1'b0;
      done      <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (follow) begin
            state_reg <= FOLLOW;
            latch_d   <= in_data;
            latch_c   <= 1'b1;
          end else if (in_valid) begin
            state_reg <= SETUP;
            latch_d   <= in_data;
            latch_c   <= 1'b0;
            cnt_reg   <= CW'(SETUP_CYC - 1);
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            state_reg <= GATE;
            latch_c   <= 1'b1;
            cnt_reg   <= CW'(PULSE_CYC - 1);
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        GATE: begin
          if (cnt_zero) begin
            state_reg <= HOLD;
            latch_c   <= 1'b0;
            cnt_reg   <= CW'(HOLD_CYC - 1);
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            state_reg <= IDLE;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        FOLLOW: begin
          if (follow) begin
            latch_d <= in_data;
          end else begin
            state_reg <= HOLD;
            latch_c   <= 1'b0;
            cnt_reg   <= CW'(HOLD_CYC - 1);
          end
        end
        default: begin
          state_reg <= IDLE;
          latch_c   <= 1'b0;
        end
      endcase
    end
  end

endmodule
